// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - operand forwarding mux plus multi-cycle op hazard scoreboard
module hazard_scoreboard #(
  parameter  int XLEN   = 64,
  parameter  int NREAD  = 2,
  parameter  int NFWD   = 2,
  parameter  int MAXOUT = 4,
  localparam int OW     = $clog2(MAXOUT + 1)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NREAD-1:0]      rd_use,
  input  logic [NREAD*5-1:0]    rd_addr,
  input  logic [NREAD*XLEN-1:0] rf_data,
  input  logic [NFWD-1:0]       src_valid,
  input  logic [NFWD*5-1:0]     src_dst,
  input  logic [NFWD*XLEN-1:0]  src_data,
  input  logic [NFWD-1:0]       src_load,
  input  logic                  iss_valid,
  input  logic [4:0]            iss_dst,
  input  logic                  cmp_valid,
  input  logic [4:0]            cmp_dst,
  input  logic                  flush,
  output logic [NREAD*XLEN-1:0] opnd,
  output logic                  stall,
  output logic [31:0]           busy,
  output logic [OW-1:0]         outstanding
);

  localparam logic [OW-1:0] MAX_CNT = OW'(MAXOUT);

  logic [31:0]   busy_q, busy_d;
  logic [OW-1:0] outstanding_q, outstanding_d;

  logic [NREAD-1:0] fwd_hit;
  logic [NREAD-1:0] fwd_load;
  logic             rd_stall;
  logic             cmp_eff;
  logic             iss_nz;
  logic             waw_stall;
  logic             cap_stall;
  logic             iss_acc;

  // Forwarding mux: scan oldest to youngest so the youngest matching source wins.
  always_comb begin
    opnd     = rf_data;
    fwd_hit  = '0;
    fwd_load = '0;
    for (int p = 0; p < NREAD; p++) begin
      for (int k = NFWD - 1; k >= 0; k--) begin
        if (src_valid[k] && (src_dst[k*5 +: 5] == rd_addr[p*5 +: 5]) &&
            (src_dst[k*5 +: 5] != 5'd0)) begin
          fwd_hit[p]               = 1'b1;
          fwd_load[p]              = src_load[k];
          opnd[p*XLEN +: XLEN]     = src_data[k*XLEN +: XLEN];
        end
      end
    end
  end

  // Read-side hazards: load-use on the selected source, RAW on a pending register.
  // A same-cycle completion to the read register lets the regfile write-through supply it.
  always_comb begin
    rd_stall = 1'b0;
    for (int p = 0; p < NREAD; p++) begin
      if (rd_use[p] && fwd_hit[p] && fwd_load[p]) begin
        rd_stall = 1'b1;
      end
      if (rd_use[p] && busy_q[rd_addr[p*5 +: 5]] &&
          !(cmp_valid && (cmp_dst == rd_addr[p*5 +: 5]))) begin
        rd_stall = 1'b1;
      end
    end
  end

  // Issue-side hazards and acceptance; x0 issues never stall and never occupy a slot.
  always_comb begin
    cmp_eff   = cmp_valid && busy_q[cmp_dst];
    iss_nz    = iss_valid && (iss_dst != 5'd0);
    waw_stall = iss_nz && busy_q[iss_dst] && !(cmp_valid && (cmp_dst == iss_dst));
    cap_stall = iss_nz && (outstanding_q == MAX_CNT) && !cmp_eff;
    stall     = rd_stall || waw_stall || cap_stall;
    iss_acc   = iss_nz && !stall;
  end

  // Next scoreboard state: clear on completion, then set on issue so a same-register pair stays busy.
  always_comb begin
    busy_d        = busy_q;
    outstanding_d = outstanding_q;
    if (flush) begin
      busy_d        = '0;
      outstanding_d = '0;
    end else begin
      if (cmp_eff) begin
        busy_d[cmp_dst] = 1'b0;
      end
      if (iss_acc) begin
        busy_d[iss_dst] = 1'b1;
      end
      outstanding_d = outstanding_q + {{(OW-1){1'b0}}, iss_acc} - {{(OW-1){1'b0}}, cmp_eff};
    end
  end

  // Scoreboard state registers with asynchronous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q        <= '0;
      outstanding_q <= '0;
    end else begin
      busy_q        <= busy_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign busy        = busy_q;
  assign outstanding = outstanding_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;
  localparam int XLEN   = 64;
  localparam int NREAD  = 2;
  localparam int NFWD   = 2;
  localparam int MAXOUT = 4;
  localparam int OW     = $clog2(MAXOUT + 1);

  logic                  clk;
  logic                  resetn;
  logic [NREAD-1:0]      rd_use;
  logic [NREAD*5-1:0]    rd_addr;
  logic [NREAD*XLEN-1:0] rf_data;
  logic [NFWD-1:0]       src_valid;
  logic [NFWD*5-1:0]     src_dst;
  logic [NFWD*XLEN-1:0]  src_data;
  logic [NFWD-1:0]       src_load;
  logic                  iss_valid;
  logic [4:0]            iss_dst;
  logic                  cmp_valid;
  logic [4:0]            cmp_dst;
  logic                  flush;
  logic [NREAD*XLEN-1:0] opnd;
  logic                  stall;
  logic [31:0]           busy;
  logic [OW-1:0]         outstanding;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_scoreboard #(.XLEN(XLEN), .NREAD(NREAD), .NFWD(NFWD), .MAXOUT(MAXOUT)) dut (
    .clk(clk), .resetn(resetn), .rd_use(rd_use), .rd_addr(rd_addr), .rf_data(rf_data),
    .src_valid(src_valid), .src_dst(src_dst), .src_data(src_data), .src_load(src_load),
    .iss_valid(iss_valid), .iss_dst(iss_dst), .cmp_valid(cmp_valid), .cmp_dst(cmp_dst),
    .flush(flush), .opnd(opnd), .stall(stall), .busy(busy), .outstanding(outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    rd_use = '0; rd_addr = '0; rf_data = '0;
    src_valid = '0; src_dst = '0; src_data = '0; src_load = '0;
    iss_valid = 1'b0; iss_dst = '0; cmp_valid = 1'b0; cmp_dst = '0; flush = 1'b0;
  endtask

  // Advance one clock; inputs are driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle();
    #2;
    n_tests++; if (busy !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h want %h", busy, 32'h0); end
    n_tests++; if (outstanding !== '0) begin n_fail++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
    rd_use = 2'b01; rd_addr = 10'd3; rf_data[63:0] = 64'h1234;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_tests++; if (opnd[63:0] !== 64'h1234) begin n_fail++; $display("FAIL reset_opnd: got %h want %h", opnd[63:0], 64'h1234); end
    tick(); tick();
    resetn = 1'b1;
    idle();
    tick();
  endtask

  task automatic test_forward_priority();
    idle();
    src_valid = 2'b11; src_dst = {5'd5, 5'd5};
    src_data = {64'hBB, 64'hAA};
    rd_use = 2'b11; rd_addr = {5'd0, 5'd5};
    rf_data = {64'h2222, 64'h1111};
    #1;
    n_tests++; if (opnd[63:0] !== 64'hAA) begin n_fail++; $display("FAIL fwd_youngest: got %h want %h", opnd[63:0], 64'hAA); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL fwd_stall: got %b want 0", stall); end
    src_dst = {5'd0, 5'd0};
    #1;
    n_tests++; if (opnd[127:64] !== 64'h2222) begin n_fail++; $display("FAIL fwd_x0: got %h want %h", opnd[127:64], 64'h2222); end
    src_dst = {5'd5, 5'd9};
    #1;
    n_tests++; if (opnd[63:0] !== 64'hBB) begin n_fail++; $display("FAIL fwd_older: got %h want %h", opnd[63:0], 64'hBB); end
    tick();
  endtask

  task automatic test_load_use();
    idle();
    src_valid = 2'b01; src_load = 2'b01; src_dst = {5'd0, 5'd7};
    rd_use = 2'b01; rd_addr = {5'd0, 5'd7};
    #1;
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL load_use_stall: got %b want 1", stall); end
    rd_use = 2'b00;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL load_no_use: got %b want 0", stall); end
    rd_use = 2'b01; src_valid = 2'b11; src_load = 2'b10; src_dst = {5'd7, 5'd7};
    src_data = {64'h0BAD, 64'h77};
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL load_masked_stall: got %b want 0", stall); end
    n_tests++; if (opnd[63:0] !== 64'h77) begin n_fail++; $display("FAIL load_masked_opnd: got %h want %h", opnd[63:0], 64'h77); end
    tick();
  endtask

  task automatic test_raw();
    idle();
    iss_valid = 1'b1; iss_dst = 5'd3;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_issue_stall: got %b want 0", stall); end
    tick();
    idle();
    n_tests++; if (busy !== 32'h8) begin n_fail++; $display("FAIL raw_busy_set: got %h want %h", busy, 32'h8); end
    n_tests++; if (outstanding !== 3'd1) begin n_fail++; $display("FAIL raw_out_one: got %0d want 1", outstanding); end
    rd_use = 2'b01; rd_addr = {5'd0, 5'd3}; rf_data[63:0] = 64'h33;
    #1;
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall: got %b want 1", stall); end
    cmp_valid = 1'b1; cmp_dst = 5'd3;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_bypass_stall: got %b want 0", stall); end
    n_tests++; if (opnd[63:0] !== 64'h33) begin n_fail++; $display("FAIL raw_bypass_opnd: got %h want %h", opnd[63:0], 64'h33); end
    tick();
    idle();
    n_tests++; if (busy !== 32'h0) begin n_fail++; $display("FAIL raw_busy_clr: got %h want 0", busy); end
    n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL raw_out_zero: got %0d want 0", outstanding); end
  endtask

  task automatic test_capacity();
    for (int d = 1; d <= 4; d++) begin
      idle(); iss_valid = 1'b1; iss_dst = 5'(d);
      tick();
    end
    idle();
    n_tests++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL cap_out_full: got %0d want 4", outstanding); end
    n_tests++; if (busy !== 32'h1E) begin n_fail++; $display("FAIL cap_busy_full: got %h want %h", busy, 32'h1E); end
    iss_valid = 1'b1; iss_dst = 5'd6;
    #1;
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL cap_stall: got %b want 1", stall); end
    tick();
    n_tests++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL cap_out_hold: got %0d want 4", outstanding); end
    n_tests++; if (busy[6] !== 1'b0) begin n_fail++; $display("FAIL cap_rejected: got %b want 0", busy[6]); end
    iss_valid = 1'b1; iss_dst = 5'd6; cmp_valid = 1'b1; cmp_dst = 5'd2;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL cap_cmp_stall: got %b want 0", stall); end
    tick();
    idle();
    n_tests++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL cap_swap_out: got %0d want 4", outstanding); end
    n_tests++; if (busy !== 32'h5A) begin n_fail++; $display("FAIL cap_swap_busy: got %h want %h", busy, 32'h5A); end
    iss_valid = 1'b1; iss_dst = 5'd4; cmp_valid = 1'b1; cmp_dst = 5'd4;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL waw_cleared: got %b want 0", stall); end
    tick();
    idle();
    n_tests++; if (busy !== 32'h5A || outstanding !== 3'd4) begin n_fail++; $display("FAIL same_reg_pair: got %h/%0d want 5a/4", busy, outstanding); end
    flush = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_flush();
    idle(); iss_valid = 1'b1; iss_dst = 5'd1; tick();
    idle(); iss_valid = 1'b1; iss_dst = 5'd2; tick();
    idle();
    n_tests++; if (busy !== 32'h6) begin n_fail++; $display("FAIL flush_pre_busy: got %h want %h", busy, 32'h6); end
    flush = 1'b1; iss_valid = 1'b1; iss_dst = 5'd9;
    tick();
    idle();
    n_tests++; if (busy !== 32'h0) begin n_fail++; $display("FAIL flush_busy: got %h want 0", busy); end
    n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL flush_out: got %0d want 0", outstanding); end
    cmp_valid = 1'b1; cmp_dst = 5'd1;
    tick();
    idle();
    n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL stale_cmp_out: got %0d want 0", outstanding); end
  endtask

  task automatic test_reset_midop();
    idle(); iss_valid = 1'b1; iss_dst = 5'd4; tick();
    idle();
    n_tests++; if (busy !== 32'h10) begin n_fail++; $display("FAIL midop_busy_set: got %h want %h", busy, 32'h10); end
    #1 resetn = 1'b0;
    #1;
    n_tests++; if (busy !== 32'h0) begin n_fail++; $display("FAIL midop_async_busy: got %h want 0", busy); end
    n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL midop_async_out: got %0d want 0", outstanding); end
    #1 resetn = 1'b1;
    iss_valid = 1'b1; iss_dst = 5'd0; rd_use = 2'b11; rd_addr = {5'd0, 5'd0};
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL x0_stall: got %b want 0", stall); end
    rd_addr = {5'd0, 5'd4};
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL midop_forgotten: got %b want 0", stall); end
    tick();
    idle();
    n_tests++; if (busy[0] !== 1'b0 || outstanding !== 3'd0) begin n_fail++; $display("FAIL x0_busy: got %b/%0d want 0/0", busy[0], outstanding); end
  endtask

  // Random traffic against a set-of-pending-registers model; outstanding is the set's population.
  task automatic test_random();
    bit [31:0] m_busy;
    logic [XLEN-1:0] exp_opnd;
    logic exp_stall;
    bit hit, ld, accepted;
    logic [4:0] a;
    idle(); flush = 1'b1; tick(); idle();
    m_busy = '0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NREAD; p++) begin
        rd_addr[p*5 +: 5]     = 5'($urandom_range(0, 7));
        rf_data[p*XLEN +: XLEN] = {$urandom, $urandom};
      end
      for (int k = 0; k < NFWD; k++) begin
        src_dst[k*5 +: 5]      = 5'($urandom_range(0, 7));
        src_data[k*XLEN +: XLEN] = {$urandom, $urandom};
      end
      rd_use    = NREAD'($urandom);
      src_valid = NFWD'($urandom);
      src_load  = NFWD'($urandom) & NFWD'($urandom);
      iss_valid = 1'($urandom);
      iss_dst   = 5'($urandom_range(0, 7));
      cmp_valid = ($urandom_range(0, 2) == 0);
      cmp_dst   = 5'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 24) == 0);
      #1;
      exp_stall = 1'b0;
      for (int p = 0; p < NREAD; p++) begin
        a = rd_addr[p*5 +: 5];
        exp_opnd = rf_data[p*XLEN +: XLEN];
        hit = 0; ld = 0;
        for (int k = 0; k < NFWD; k++) begin
          if (!hit && src_valid[k] && src_dst[k*5 +: 5] == a && a != 0) begin
            hit = 1; ld = src_load[k]; exp_opnd = src_data[k*XLEN +: XLEN];
          end
        end
        if (rd_use[p] && ld) exp_stall = 1'b1;
        if (rd_use[p] && m_busy[a] && !(cmp_valid && cmp_dst == a)) exp_stall = 1'b1;
        n_tests++;
        if (opnd[p*XLEN +: XLEN] !== exp_opnd) begin
          n_fail++; $display("FAIL rand_opnd cycle %0d port %0d: got %h want %h", c, p, opnd[p*XLEN +: XLEN], exp_opnd);
        end
      end
      if (iss_valid && iss_dst != 0) begin
        if (m_busy[iss_dst] && !(cmp_valid && cmp_dst == iss_dst)) exp_stall = 1'b1;
        if ($countones(m_busy) == MAXOUT && !(cmp_valid && m_busy[cmp_dst])) exp_stall = 1'b1;
      end
      n_tests++;
      if (stall !== exp_stall) begin
        n_fail++; $display("FAIL rand_stall cycle %0d: got %b want %b", c, stall, exp_stall);
      end
      accepted = iss_valid && iss_dst != 0 && !exp_stall;
      if (flush) m_busy = '0;
      else begin
        if (cmp_valid) m_busy[cmp_dst] = 1'b0;
        if (accepted) m_busy[iss_dst] = 1'b1;
      end
      tick();
      n_tests++;
      if (busy !== m_busy || int'(outstanding) != $countones(m_busy)) begin
        n_fail++; $display("FAIL rand_state cycle %0d: got %h/%0d want %h/%0d", c, busy, outstanding, m_busy, $countones(m_busy));
      end
    end
    idle();
  endtask

  initial begin
    resetn = 1'b0;
    idle();
    #1;
    test_reset();
    test_forward_priority();
    test_load_use();
    test_raw();
    test_capacity();
    test_flush();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter XLEN, default 64, datapath width in bits.
REQ-002 Parameter NREAD, default 2, number of operand read ports.
REQ-003 Parameter NFWD, default 2, number of forwarding sources; index 0 is the youngest stage (execute), index 1 is memory.
REQ-004 Parameter MAXOUT, default 4, maximum outstanding multi-cycle ops; OW = $clog2(MAXOUT+1).
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 resetn  in  1  asynchronous active-low reset.
REQ-008 rd_use  in  NREAD  port p reads a source register this cycle.
REQ-009 rd_addr  in  NREAD*5  register index per port.
REQ-010 rf_data  in  NREAD*XLEN  register-file read data per port.
REQ-011 src_valid  in  NFWD  source k will write a register.
REQ-012 src_dst  in  NFWD*5  destination of source k.
REQ-013 src_data  in  NFWD*XLEN  result of source k.
REQ-014 src_load  in  NFWD  source k result not yet available (load in flight).
REQ-015 iss_valid  in  1  decode requests issue of a multi-cycle op (mul/div).
REQ-016 iss_dst  in  5  destination of the issuing op.
REQ-017 cmp_valid  in  1  a multi-cycle unit writes back this cycle.
REQ-018 cmp_dst  in  5  destination of the completing op.
REQ-019 flush  in  1  pipeline flush; discard all pending scoreboard state.
REQ-020 opnd  out  NREAD*XLEN  forwarded operand per port.
REQ-021 stall  out  1  decode must hold this cycle.
REQ-022 busy  out  32  per-register pending-write bitmap (registered).
REQ-023 outstanding  out  OW  count of busy registers (registered).

Function
REQ-024 Per port p: opnd[p] = src_data[k] for the lowest k with src_valid[k], src_dst[k]==rd_addr[p], src_dst[k]!=0; else rf_data[p]; combinational.
REQ-025 Register 0 never forwards, never marks busy, never stalls.
REQ-026 Load-use: stall=1 when rd_use[p] and the selected source k has src_load[k]=1; a younger non-load match masks an older load match.
REQ-027 RAW on scoreboard: stall=1 when rd_use[p] and busy[rd_addr[p]]=1, unless cmp_valid with cmp_dst==rd_addr[p] this cycle (completion bypass: opnd[p]=rf_data[p], regfile write-through assumed).
REQ-028 WAW: stall=1 when iss_valid and busy[iss_dst]=1 and not cleared by a same-cycle completion.
REQ-029 Capacity: stall=1 when iss_valid and outstanding==MAXOUT and no completion this cycle.
REQ-030 Issue is accepted only when iss_valid=1 and stall=0; accepted issue sets busy[iss_dst] at next edge.
REQ-031 Completion clears busy[cmp_dst] at next edge; completion to a non-busy register is ignored (no counter underflow).
REQ-032 Same-cycle accepted issue and completion to the same register: busy stays 1, outstanding unchanged.
REQ-033 outstanding next = outstanding + accepted_issue - valid_completion; never exceeds MAXOUT, never below 0.
REQ-034 flush=1: busy and outstanding become 0 at next edge; flush overrides issue and completion that cycle; stall is still computed from current state that cycle.
REQ-035 stall is purely combinational from inputs and registered state; no added latency.

Reset
REQ-036 resetn=0 asynchronously forces busy=0 and outstanding=0; opnd follows REQ-024 during reset.
REQ-037 Stall during reset derives only from forwarding inputs (scoreboard empty).
REQ-038 Reset deassertion mid-operation: first post-reset edge behaves as empty scoreboard; prior pending ops are forgotten.

Verification
REQ-039 src0 {valid,dst=5,data=0xAA}, src1 {valid,dst=5,data=0xBB}, rd_addr[0]=5 -> opnd[0]=0xAA, stall=0.
REQ-040 src0 {valid,load,dst=7}, rd_use[0], rd_addr[0]=7 -> stall=1; same with src1 load and src0 non-load on 7 -> stall=0, opnd=src0 data.
REQ-041 Issue dst=3; next cycle read x3 -> stall=1; cmp_valid dst=3 -> stall=0 same cycle, busy[3]=0 next cycle.
REQ-042 MAXOUT=4: issue dst 1..4 on four cycles, fifth issue dst=6 -> stall=1, outstanding=4; completion of 2 with fifth issue -> accepted, outstanding stays 4.
REQ-043 Busy {1,2}, flush with simultaneous issue dst=9 -> busy=0, outstanding=0 next cycle; later cmp_valid dst=1 -> ignored, outstanding=0.
REQ-044 Busy {4}, resetn pulsed low between edges -> busy=0 immediately; issue and rd_use to x0 -> never stall, busy[0]=0.
